// File: rtl/apb_reg_pkg.sv
// apb_reg_pkg: shared FSM state type and width helpers for the APB register slave.
package apb_reg_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int WAIT_W = 4;
  function automatic int off_w(int data_w);
    return $clog2(data_w / 8);
  endfunction
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/apb_reg_slave_if.sv
// apb_reg_slave_if: APB3/APB4 bus bundle; pstrb exists only when APB_REG_PSTRB_EN is defined.
interface apb_reg_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic psel;
  logic penable;
  logic pwrite;
  logic [DATA_W-1:0] pwdata;
  logic pready;
  logic [DATA_W-1:0] prdata;
  logic pslverr;
`ifdef APB_REG_PSTRB_EN
  logic [DATA_W/8-1:0] pstrb;
  modport master (output paddr, psel, penable, pwrite, pwdata, pstrb, input pready, prdata, pslverr);
  modport slave (input paddr, psel, penable, pwrite, pwdata, pstrb, output pready, prdata, pslverr);
`else
  modport master (output paddr, psel, penable, pwrite, pwdata, input pready, prdata, pslverr);
  modport slave (input paddr, psel, penable, pwrite, pwdata, output pready, prdata, pslverr);
`endif
endinterface

// File: rtl/apb_reg_file.sv
// apb_reg_file: register storage with byte-lane write masking and registered per-register write pulses.
module apb_reg_file #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 8,
  parameter int IDX_W = 3,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [IDX_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0] rdata,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0] wr_pulse
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  assign rdata = regs[idx];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= RESET_VAL;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (we) begin
        for (int b = 0; b < DATA_W / 8; b++)
          if (strb[b]) regs[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        wr_pulse[idx] <= |strb;
      end
    end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[i*DATA_W +: DATA_W] = regs[i];
  end
endmodule

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB completer with NUM_REGS registers and WAIT_STATES wait cycles per transfer.
// Define APB_REG_PSTRB_EN to add pstrb byte-lane writes (reads with pstrb != 0 then error).
module apb_reg_slave import apb_reg_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic pclk,
  input  logic preset,
  apb_reg_slave_if.slave bus,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0] wr_pulse
);
  localparam int OFF_W = off_w(DATA_W);
  localparam int IDX_W = idx_w(NUM_REGS);
  localparam int STRB_W = DATA_W / 8;
  state_t state;
  logic [WAIT_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_q, a, word;
  logic [DATA_W-1:0] wdata_q, rd_word, rd_data;
  logic [IDX_W-1:0] idx;
  logic [STRB_W-1:0] s;
  logic wr_q, err_q, w, s_err, err, we;
  // In IDLE the live bus is decoded so a zero-wait response can be built at the setup edge.
  assign a = (state == IDLE) ? bus.paddr : addr_q;
  assign w = (state == IDLE) ? bus.pwrite : wr_q;
`ifdef APB_REG_PSTRB_EN
  logic [STRB_W-1:0] strb_q;
  assign s = (state == IDLE) ? bus.pstrb : strb_q;
  assign s_err = !w && |s;
`else
  assign s = '1;
  assign s_err = 1'b0;
`endif
  always_comb begin
    word = a >> OFF_W;
    idx = IDX_W'(word);
    err = |(a & ADDR_W'((1 << OFF_W) - 1)) || word >= ADDR_W'(NUM_REGS) || s_err;
    rd_data = (err || w) ? '0 : rd_word;
  end
  assign we = state == RESP && bus.psel && wr_q && !err_q;
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
`ifdef APB_REG_PSTRB_EN
      strb_q <= '0;
`endif
      bus.pready <= 1'b0;
      bus.pslverr <= 1'b0;
      bus.prdata <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.psel && !bus.penable) begin
            addr_q <= bus.paddr;
            wr_q <= bus.pwrite;
            wdata_q <= bus.pwdata;
            err_q <= err;
            cnt <= WAIT_W'(WAIT_STATES);
`ifdef APB_REG_PSTRB_EN
            strb_q <= bus.pstrb;
`endif
            if (WAIT_STATES == 0) begin
              state <= RESP;
              bus.pready <= 1'b1;
              bus.pslverr <= err;
              bus.prdata <= rd_data;
            end else state <= WAIT;
          end
        WAIT:
          if (!bus.psel) state <= IDLE;
          else if (bus.penable) begin
            cnt <= cnt - 1'b1;
            if (cnt == WAIT_W'(1)) begin
              state <= RESP;
              bus.pready <= 1'b1;
              bus.pslverr <= err_q;
              bus.prdata <= rd_data;
            end
          end
        default: begin
          state <= IDLE;
          bus.pready <= 1'b0;
          bus.pslverr <= 1'b0;
          bus.prdata <= '0;
        end
      endcase
    end
  apb_reg_file #(
    .DATA_W(DATA_W),
    .NUM_REGS(NUM_REGS),
    .IDX_W(IDX_W),
    .RESET_VAL(RESET_VAL)
  ) u_file (
    .clk(pclk),
    .rst(preset),
    .we(we),
    .idx(idx),
    .wdata(wdata_q),
    .strb(s),
    .rdata(rd_word),
    .reg_q(reg_q),
    .wr_pulse(wr_pulse)
  );
endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: random and directed APB transfers checked against a word-array model.
// Define APB_REG_PSTRB_EN to exercise byte-lane writes.
module tb_apb_reg_slave;
  localparam int WS = 2;
  localparam logic [31:0] RV = 32'h0000_A5A5;
  logic clk = 1'b0;
  logic preset;
  logic [255:0] reg_q;
  logic [7:0] wr_pulse;
  logic [31:0] model [8];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  apb_reg_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_reg_slave #(
    .ADDR_W(32),
    .DATA_W(32),
    .NUM_REGS(8),
    .WAIT_STATES(WS),
    .RESET_VAL(RV)
  ) dut (
    .pclk(clk),
    .preset(preset),
    .bus(bus),
    .reg_q(reg_q),
    .wr_pulse(wr_pulse)
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] flat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction
  function automatic logic [3:0] eff(input logic [3:0] s);
`ifdef APB_REG_PSTRB_EN
    return s;
`else
    return 4'hF;
`endif
  endfunction
  function automatic logic bad(input logic [31:0] a, input logic w, input logic [3:0] s);
    logic e;
    e = a[1:0] != 2'd0 || (a >> 2) >= 32'd8;
`ifdef APB_REG_PSTRB_EN
    e = e || (!w && s != 4'd0);
`endif
    return e;
  endfunction
  task automatic drive_setup(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    bus.psel = 1'b1;
    bus.penable = 1'b0;
    bus.paddr = a;
    bus.pwrite = w;
    bus.pwdata = d;
`ifdef APB_REG_PSTRB_EN
    bus.pstrb = s;
`endif
    if (s === 4'bx) bus.psel = 1'b1;
  endtask
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    logic exp_e;
    logic [31:0] exp_rd;
    logic [7:0] exp_p;
    int acc;
    exp_e = bad(a, w, s);
    exp_rd = (w || exp_e) ? 32'd0 : model[a[4:2]];
    drive_setup(a, w, d, s);
    @(posedge clk); #1;
    bus.penable = 1'b1;
    acc = 1;
    while (!bus.pready && acc <= WS + 4) begin
      chk("pulse_quiet", wr_pulse, 0);
      @(posedge clk); #1;
      acc++;
    end
    chk("latency", acc, WS + 1);
    chk("pslverr", bus.pslverr, exp_e);
    chk("prdata", bus.prdata, exp_rd);
    @(posedge clk); #1;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    exp_p = 8'd0;
    if (w && !exp_e) begin
      for (int b = 0; b < 4; b++)
        if (eff(s)[b]) model[a[4:2]][b*8 +: 8] = d[b*8 +: 8];
      if (eff(s) != 4'd0) exp_p = 8'd1 << a[4:2];
    end
    chk("pready_clr", bus.pready, 0);
    chk("prdata_clr", bus.prdata, 0);
    chk("wr_pulse", wr_pulse, exp_p);
    chk("reg_q", reg_q, flat());
  endtask
  task automatic abort(input logic [31:0] a, input logic [31:0] d, input int n);
    drive_setup(a, 1'b1, d, 4'hF);
    @(posedge clk); #1;
    bus.penable = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    @(posedge clk); #1;
    chk("abort_pready", bus.pready, 0);
    chk("abort_pulse", wr_pulse, 0);
    chk("abort_reg", reg_q, flat());
  endtask
  initial begin
    logic [31:0] a;
    logic [3:0] s;
    logic w;
    preset = 1'b1;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    bus.paddr = '0;
    bus.pwrite = 1'b0;
    bus.pwdata = '0;
`ifdef APB_REG_PSTRB_EN
    bus.pstrb = '0;
`endif
    for (int i = 0; i < 8; i++) model[i] = RV;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg", reg_q, {8{RV}});
    chk("rst_pready", bus.pready, 0);
    chk("rst_pslverr", bus.pslverr, 0);
    chk("rst_prdata", bus.prdata, 0);
    chk("rst_pulse", wr_pulse, 0);
    preset = 1'b0;
    @(posedge clk); #1;
    xfer(32'h08, 1'b1, 32'hDEAD_BEEF, 4'hF);
    xfer(32'h08, 1'b0, 32'h0, 4'h0);
    chk("reg2", reg_q[95:64], 32'hDEAD_BEEF);
    xfer(32'h20, 1'b1, 32'h1234_5678, 4'hF);
    xfer(32'h06, 1'b0, 32'h0, 4'h0);
    xfer(32'h00, 1'b1, 32'hCAFE_F00D, 4'hF);
    xfer(32'h00, 1'b0, 32'h0, 4'h0);
    abort(32'h04, 32'h5555_AAAA, 1);
    xfer(32'h04, 1'b0, 32'h0, 4'h0);
    abort(32'h04, 32'h6666_BBBB, WS);
    xfer(32'h04, 1'b1, 32'h7777_CCCC, 4'hF);
    bus.psel = 1'b1;
    bus.penable = 1'b1;
    bus.pwrite = 1'b1;
    bus.paddr = 32'h0C;
    bus.pwdata = 32'h0BAD_0BAD;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_penable", bus.pready, 0);
    end
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    chk("idle_penable_reg", reg_q, flat());
`ifdef APB_REG_PSTRB_EN
    xfer(32'h00, 1'b1, 32'h1122_3344, 4'hF);
    xfer(32'h00, 1'b1, 32'hAABB_CCDD, 4'b0101);
    chk("strb_merge", reg_q[31:0], 32'h11BB_33DD);
    xfer(32'h00, 1'b0, 32'h0, 4'b0001);
    xfer(32'h00, 1'b1, 32'hFFFF_FFFF, 4'b0000);
`endif
    drive_setup(32'h10, 1'b1, 32'h1357_9BDF, 4'hF);
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #3;
    preset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) model[i] = RV;
    chk("rst_mid_reg", reg_q, {8{RV}});
    chk("rst_mid_pready", bus.pready, 0);
    chk("rst_mid_pulse", wr_pulse, 0);
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    @(posedge clk); #1;
    preset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_after", reg_q, flat());
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 3))
        0, 1: a = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
        2: a = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(1, 3))};
        default: a = ($urandom | 32'h20) & ~32'h3;
      endcase
      w = 1'($urandom);
      s = w ? 4'($urandom) : ($urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0);
      xfer(a, w, $urandom, s);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        chk("gap_pulse", wr_pulse, 0);
      end
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
